// File: rtl/debounce_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and
// glitch counter sizing.
package debounce_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } state_t;

    localparam int                  GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

endpackage

// File: rtl/sync_ff.sv
// SYNC_STAGES-deep flop chain that brings an asynchronous level into the
// local clock domain; reusable for any asynchronous single-bit input.
module sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic in_clock,
    input  logic in_reset,
    input  logic in_data,
    output logic out_data
);

    logic [SYNC_STAGES-1:0] chain;

    // Pure flop-to-flop chain: nothing may sit between stages.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            chain <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], in_data};
        end
    end

    assign out_data = chain[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a raw level and only accepts a new value after it has held
// for STABLE_CYCLES synchronised cycles. Optional DEBOUNCER_GLITCH_CNT_EN
// adds a saturating count of rejected glitches.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic                in_clock,
    input  logic                in_reset,
    input  logic                in_signal,
`ifdef DEBOUNCER_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] out_glitch_count,
`endif
    output logic                out_signal,
    output logic                out_busy
);

    localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);

    logic             sync_q;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    sync_ff #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_data  (in_signal),
        .out_data (sync_q)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    // The first differing cycle loads 1, so the accept fires exactly on the
    // STABLE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state      <= STABLE;
            cnt        <= '0;
            out_signal <= RESET_LEVEL;
            out_busy   <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (sync_q != out_signal) begin
                        if (STABLE_CYCLES == 1) begin
                            out_signal <= ~out_signal;
                        end else begin
                            state    <= CONFIRM;
                            cnt      <= CNT_W'(1);
                            out_busy <= 1'b1;
                        end
                    end
                end
                CONFIRM: begin
                    if (sync_q != out_signal) begin
                        if (cnt_inc == STABLE_MAX) begin
                            out_signal <= ~out_signal;
                            cnt        <= '0;
                            state      <= STABLE;
                            out_busy   <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Level reverted before confirmation: reject as a glitch.
                        cnt      <= '0;
                        state    <= STABLE;
                        out_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= STABLE;
                    cnt      <= '0;
                    out_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCER_GLITCH_CNT_EN
    logic abort;

    assign abort = (state == CONFIRM) && (sync_q == out_signal);

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            out_glitch_count <= '0;
        end else if (abort && (out_glitch_count != GLITCH_MAX)) begin
            out_glitch_count <= out_glitch_count + GLITCH_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4): the
// driver pushes expected output transitions, a monitor pops and checks them.
module tb_input_debouncer;

    logic       in_clock = 1'b0;
    logic       in_reset;
    logic       in_signal;
    logic       out_signal;
    logic       out_busy;
`ifdef DEBOUNCER_GLITCH_CNT_EN
    logic [7:0] out_glitch_count;
`endif

    input_debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .in_clock         (in_clock),
        .in_reset         (in_reset),
        .in_signal        (in_signal),
`ifdef DEBOUNCER_GLITCH_CNT_EN
        .out_glitch_count (out_glitch_count),
`endif
        .out_signal       (out_signal),
        .out_busy         (out_busy)
    );

    // clock / cycle counter
    always #5 in_clock = ~in_clock;

    int cyc = 0;
    always @(posedge in_clock) cyc <= cyc + 1;

    // scoreboard state: {level, cycle} of each expected out_signal transition
    logic [32:0] exp_q[$];
    int          checks     = 0;
    int          passes     = 0;
    int          rise_count = 0;
    int          glitch_exp = 0;
    logic        mon_en     = 1'b0;
    logic        prev_out   = 1'b0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_glitch();
`ifdef DEBOUNCER_GLITCH_CNT_EN
        check_int("glitch_count", int'(out_glitch_count), glitch_exp);
`endif
    endtask

    // driver tasks: inputs change on the falling edge
    task automatic set_raw(input logic v);
        @(negedge in_clock);
        in_signal = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge in_clock);
    endtask

    task automatic expect_toggle(input int at_cycle, input logic level);
        exp_q.push_back({level, 32'(at_cycle)});
    endtask

    // monitor: every out_signal change must match the head of the queue
    always @(negedge in_clock) begin
        logic [32:0] e;
        if (mon_en && (out_signal !== prev_out)) begin
            if (out_signal === 1'b1) rise_count++;
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL spurious_toggle: out_signal=%0b at cycle %0d, required no change",
                         out_signal, cyc);
            end else begin
                e = exp_q.pop_front();
                check_int("toggle_cycle", cyc, int'(e[31:0]));
                check_bit("toggle_level", out_signal, e[32]);
            end
        end
        prev_out = out_signal;
    end

    initial begin
        int   n0;
        int   r0;
        logic bounce [9];
        bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // reset
        in_reset  = 1'b1;
        in_signal = 1'b0;
        wait_cycles(3);
        in_reset = 1'b0;
        check_bit("reset_out", out_signal, 1'b0);
        check_bit("reset_busy", out_busy, 1'b0);
        check_glitch();
        mon_en = 1'b1;
        wait_cycles(2);

        // clean rise: out at edge 6, busy high for exactly 3 cycles before
        set_raw(1'b1);
        n0 = cyc;
        expect_toggle(n0 + 6, 1'b1);
        wait_cycles(2);
        check_bit("rise_busy_pre", out_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_cycles(1);
            check_bit("rise_busy_run", out_busy, 1'b1);
        end
        wait_cycles(1);
        check_bit("rise_busy_post", out_busy, 1'b0);
        check_bit("rise_out", out_signal, 1'b1);
        wait_cycles(14);

        // clean fall: same latency
        set_raw(1'b0);
        expect_toggle(cyc + 6, 1'b0);
        wait_cycles(20);

        // short pulse: 3 cycles high is rejected
        set_raw(1'b1);
        wait_cycles(2);
        set_raw(1'b0);
        check_bit("pulse_busy_mid", out_busy, 1'b1);
        wait_cycles(10);
        glitch_exp += 1;
        check_bit("pulse_out", out_signal, 1'b0);
        check_bit("pulse_busy_end", out_busy, 1'b0);
        check_glitch();

        // bounce: one rise, 6 cycles after the final 0->1
        for (int i = 0; i < 9; i++) begin
            set_raw(bounce[i]);
            if (i == 5) expect_toggle(cyc + 6, 1'b1);
        end
        wait_cycles(15);
        glitch_exp += 2;
        check_glitch();
        set_raw(1'b0);
        expect_toggle(cyc + 6, 1'b0);
        wait_cycles(15);

        // reset mid-confirm: pending rise discarded, restarts after reset
        set_raw(1'b1);
        n0 = cyc;
        expect_toggle(n0 + 10, 1'b1);
        wait_cycles(3);
        check_bit("rmc_busy_before", out_busy, 1'b1);
        in_reset = 1'b1;
        wait_cycles(1);
        in_reset = 1'b0;
        check_bit("rmc_out", out_signal, 1'b0);
        check_bit("rmc_busy", out_busy, 1'b0);
        glitch_exp = 0;
        check_glitch();
        wait_cycles(10);
        set_raw(1'b0);
        expect_toggle(cyc + 6, 1'b0);
        wait_cycles(15);

        // five bouncy presses -> five clean rises
        r0 = rise_count;
        for (int p = 0; p < 5; p++) begin
            set_raw(1'b1);
            set_raw(1'b0);
            set_raw(1'b1);
            expect_toggle(cyc + 6, 1'b1);
            wait_cycles(10);
            set_raw(1'b0);
            set_raw(1'b1);
            set_raw(1'b0);
            expect_toggle(cyc + 6, 1'b0);
            wait_cycles(10);
        end
        glitch_exp += 10;
        check_int("press_count", rise_count - r0, 5);
        check_glitch();

`ifdef DEBOUNCER_GLITCH_CNT_EN
        // saturation: 300 two-cycle pulses
        for (int i = 0; i < 300; i++) begin
            set_raw(1'b1);
            set_raw(1'b1);
            set_raw(1'b0);
            set_raw(1'b0);
        end
        wait_cycles(5);
        glitch_exp = 255;
        check_glitch();
        for (int i = 0; i < 5; i++) begin
            set_raw(1'b1);
            set_raw(1'b1);
            set_raw(1'b0);
            set_raw(1'b0);
        end
        wait_cycles(5);
        check_glitch();
        check_bit("sat_out", out_signal, 1'b0);
`endif

        // drain: every expected transition must have been seen
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cycles(1);
        check_int("pending_transitions", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
